// File: rtl/vswitch_output_arbiter.sv
// Packet-granular round-robin merge of NUM_VSWITCH AXI-Stream sources into one
// egress stream. A grant is held from the first beat until the beat carrying tlast.
// Each source has an enable bit and a wrapping count of packets it has forwarded.
module vswitch_output_arbiter #(
   parameter  int C_AXIS_DATA_WIDTH  = 256,
   parameter  int C_AXIS_TUSER_WIDTH = 128,
   parameter  int NUM_VSWITCH        = 4,
   parameter  int CNT_WIDTH          = 32,
   localparam int IDX_W              = $clog2(NUM_VSWITCH),
   localparam int KEEP_W             = C_AXIS_DATA_WIDTH / 8
) (
   input  logic                                     axis_aclk,
   input  logic                                     axis_reset,
   input  logic [NUM_VSWITCH*C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [NUM_VSWITCH*KEEP_W-1:0]             s_axis_tkeep,
   input  logic [NUM_VSWITCH*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
   input  logic [NUM_VSWITCH-1:0]                   s_axis_tvalid,
   output logic [NUM_VSWITCH-1:0]                   s_axis_tready,
   input  logic [NUM_VSWITCH-1:0]                   s_axis_tlast,
   output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
   output logic [KEEP_W-1:0]                         m_axis_tkeep,
   output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
   output logic                                     m_axis_tvalid,
   input  logic                                     m_axis_tready,
   output logic                                     m_axis_tlast,
   input  logic [NUM_VSWITCH-1:0]                   port_enable,
   output logic [NUM_VSWITCH*CNT_WIDTH-1:0]          pkt_count,
   output logic [IDX_W-1:0]                         grant_idx
);

   typedef enum logic {IDLE, FWD} state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [IDX_W-1:0]       rr_ptr;
   logic [NUM_VSWITCH-1:0] cand;
   logic                   win_found;
   logic [IDX_W-1:0]       win_idx;
   logic                   pkt_done;
   logic [CNT_WIDTH-1:0]   cnt [NUM_VSWITCH];

   assign cand     = s_axis_tvalid & port_enable;
   assign pkt_done = (state == FWD) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // Round-robin pick: scanning downward lets the candidate nearest rr_ptr win last.
   always_comb begin
      int               j;
      logic [IDX_W-1:0] j_idx;
      j         = 0;
      j_idx     = '0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = NUM_VSWITCH - 1; k >= 0; k--) begin
         j     = (int'(rr_ptr) + k) % NUM_VSWITCH;
         j_idx = IDX_W'(j);
         if (cand[j_idx]) begin
            win_found = 1'b1;
            win_idx   = j_idx;
         end
      end
   end

   // Next-state logic: arbitrate in IDLE, hold the grant until the tlast handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_found) state_nxt = FWD;
         FWD:     if (pkt_done)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output mux: the granted slice passes straight through, with no data register.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tuser  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      if (state == FWD) begin
         m_axis_tdata  = s_axis_tdata[int'(grant_idx)*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
         m_axis_tkeep  = s_axis_tkeep[int'(grant_idx)*KEEP_W +: KEEP_W];
         m_axis_tuser  = s_axis_tuser[int'(grant_idx)*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
         m_axis_tvalid = s_axis_tvalid[grant_idx];
         m_axis_tlast  = s_axis_tlast[grant_idx];
         s_axis_tready[grant_idx] = m_axis_tready;
      end
   end

   // State register.
   always_ff @(posedge axis_aclk) begin
      if (axis_reset) state <= IDLE;
      else            state <= state_nxt;
   end

   // Grant capture in IDLE; the pointer moves past the finished source at tlast.
   always_ff @(posedge axis_aclk) begin
      if (axis_reset) begin
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else begin
         if (state == IDLE && win_found) grant_idx <= win_idx;
         if (pkt_done) begin
            rr_ptr <= (int'(grant_idx) == NUM_VSWITCH - 1) ? '0 : grant_idx + IDX_W'(1);
         end
      end
   end

   // Per-source forwarded-packet counters; they wrap silently.
   always_ff @(posedge axis_aclk) begin
      if (axis_reset) begin
         for (int i = 0; i < NUM_VSWITCH; i++) cnt[i] <= '0;
      end else if (pkt_done) begin
         cnt[grant_idx] <= cnt[grant_idx] + CNT_WIDTH'(1);
      end
   end

   for (genvar g = 0; g < NUM_VSWITCH; g++) begin : g_cnt
      assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
   end

endmodule
